// File: rtl/calc_pkg.sv
// calc_pkg: opcodes, FSM states and error constants shared by the calculator
package calc_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_SET  = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
endpackage

// File: rtl/seq_calculator_if.sv
// seq_calculator_if: operand/opcode request and result bundle of the calculator
interface seq_calculator_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0]   input_a;
  logic [WIDTH-1:0]   input_b;
  logic [2:0]         func;
  logic               start;
  logic               busy;
  logic               res_valid;
  logic [2*WIDTH-1:0] res;
  logic               err;
  modport master (output input_a, input_b, func, start, input busy, res_valid, res, err);
  modport slave  (input input_a, input_b, func, start, output busy, res_valid, res, err);
endinterface

// File: rtl/seq_muldiv_engine.sv
// seq_muldiv_engine: shared accumulator running WIDTH steps of shift-add mul or restoring div
module seq_muldiv_engine #(parameter int WIDTH = 4) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_res
);
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic               r_run;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_nxt;
  // mul: acc = {partial, multiplier}; div: acc = {remainder, dividend/quotient}
  assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff = w_sh - {1'b0, r_b};
  assign w_ge   = !w_diff[WIDTH];
  assign w_nxt  = r_div ? {w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge}
                        : {w_sum, r_acc[WIDTH-1:1]};
  assign o_done = r_run & (r_cnt == CW'(WIDTH - 1));
  assign o_res  = w_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_div <= 1'b0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_acc <= {{WIDTH{1'b0}}, i_a};
      r_b   <= i_b;
      r_cnt <= '0;
      r_div <= i_div;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_acc <= w_nxt;
      r_cnt <= r_cnt + 1'b1;
      r_run <= !o_done;
    end
  end
endmodule

// File: rtl/seq_calculator.sv
// seq_calculator: clocked calculator with 1-cycle ALU ops and an iterative mul/div engine
module seq_calculator import calc_pkg::*; #(parameter int WIDTH = 4) (
  input logic              clk,
  input logic              rst,
  seq_calculator_if.slave  bus
);
  localparam int W2 = 2 * WIDTH;
  state_t          r_state;
  logic            r_busy;
  logic            r_valid;
  logic            r_err;
  logic [W2-1:0]   r_res;
  logic            w_go;
  logic            w_dz;
  logic            w_iter;
  logic            w_err;
  logic            w_eng_done;
  logic [W2-1:0]   w_ax;
  logic [W2-1:0]   w_bx;
  logic [W2-1:0]   w_alu;
  logic [W2-1:0]   w_eng_res;
  assign w_go   = bus.start & (r_state != S_ITER);
  assign w_dz   = (bus.func == OP_DIV) & (bus.input_b == '0);
  assign w_iter = ((bus.func == OP_MUL) | (bus.func == OP_DIV)) & !w_dz;
  assign w_ax   = W2'(bus.input_a);
  assign w_bx   = W2'(bus.input_b);
  assign w_err  = (w_dz | (bus.func[2:1] == 2'b11)) ? ERR_SET : ERR_NONE;
  assign w_alu  = (bus.func == OP_ADD) ? w_ax + w_bx :
                  (bus.func == OP_SUB) ? w_ax - w_bx :
                  (bus.func == OP_AND) ? w_ax & w_bx :
                  (bus.func == OP_OR)  ? w_ax | w_bx :
                  w_dz ? '1 : '0;
  seq_muldiv_engine #(.WIDTH(WIDTH)) u_eng (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_go & w_iter),
    .i_div   (bus.func == OP_DIV),
    .i_a     (bus.input_a),
    .i_b     (bus.input_b),
    .o_done  (w_eng_done),
    .o_res   (w_eng_res)
  );
  // DONE behaves like IDLE for acceptance so a start alongside res_valid is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_res   <= '0;
      r_err   <= ERR_NONE;
    end else begin
      r_valid <= 1'b0;
      if (r_state == S_ITER) begin
        if (w_eng_done) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
          r_res   <= w_eng_res;
          r_err   <= ERR_NONE;
        end
      end else if (w_go & w_iter) begin
        r_state <= S_ITER;
        r_busy  <= 1'b1;
      end else if (w_go) begin
        r_state <= S_IDLE;
        r_valid <= 1'b1;
        r_res   <= w_alu;
        r_err   <= w_err;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end
  assign bus.busy      = r_busy;
  assign bus.res_valid = r_valid;
  assign bus.res       = r_res;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_seq_calculator.sv
// tb_seq_calculator: directed WIDTH=4 checks plus randomized WIDTH=8 run against an arithmetic model
module tb_seq_calculator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   v8 = 0;
  int   n8 = 0;
  seq_calculator_if #(.WIDTH(4)) if4 ();
  seq_calculator_if #(.WIDTH(8)) if8 ();
  seq_calculator #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  seq_calculator #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  always #5 clk = ~clk;
  always @(negedge clk) if (if8.res_valid === 1'b1) v8++;
  function automatic logic [31:0] rs(int s);
    return s != 0 ? 32'(if8.res) : 32'(if4.res);
  endfunction
  function automatic logic vld(int s);
    return s != 0 ? if8.res_valid : if4.res_valid;
  endfunction
  function automatic logic bsy(int s);
    return s != 0 ? if8.busy : if4.busy;
  endfunction
  function automatic logic er(int s);
    return s != 0 ? if8.err : if4.err;
  endfunction
  task automatic drive(int s, int unsigned a, int unsigned b, int unsigned f, logic st);
    if (s != 0) begin
      if8.input_a = 8'(a); if8.input_b = 8'(b); if8.func = 3'(f); if8.start = st;
    end else begin
      if4.input_a = 4'(a); if4.input_b = 4'(b); if4.func = 3'(f); if4.start = st;
    end
  endtask
  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  // Model: results straight from integer arithmetic on the operands.
  function automatic int unsigned model(int w, int unsigned a, int unsigned b, int unsigned f, output bit e);
    int unsigned m = (32'd1 << (2 * w)) - 1;
    e = 1'b0;
    case (f)
      0: return a + b;
      1: return (a - b) & m;
      2: return a * b;
      3: begin
        if (b == 0) begin e = 1'b1; return m; end
        return ((a % b) << w) | (a / b);
      end
      4: return a & b;
      5: return a | b;
      default: begin e = 1'b1; return 0; end
    endcase
  endfunction
  task automatic run(int s, int unsigned a, int unsigned b, int unsigned f,
                     int unsigned eres, bit eerr, int ebusy, string tag);
    int n = 0;
    int bc = 0;
    @(negedge clk) drive(s, a, b, f, 1'b1);
    @(negedge clk) drive(s, ~a, ~b, 7 - f, 1'b0);
    while (vld(s) !== 1'b1 && n < 100) begin
      if (bsy(s) === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    chk({tag, " valid"}, 32'(vld(s)), 1);
    chk({tag, " res"}, rs(s), eres);
    chk({tag, " err"}, 32'(er(s)), 32'(eerr));
    chk({tag, " busycycles"}, bc, ebusy);
    chk({tag, " busy_at_valid"}, 32'(bsy(s)), 0);
    @(negedge clk);
    chk({tag, " pulse"}, 32'(vld(s)), 0);
  endtask
  initial begin
    int cnt;
    bit e;
    int unsigned a, b, f, r;
    drive(0, 0, 0, 0, 1'b0);
    drive(1, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(if4.busy), 0);
    chk("rst valid", 32'(if4.res_valid), 0);
    chk("rst res", 32'(if4.res), 0);
    chk("rst err", 32'(if4.err), 0);
    chk("rst res8", 32'(if8.res), 0);
    rst = 1'b0;
    run(0, 5, 2, 0, 'h07, 0, 0, "add5_2");
    run(0, 5, 2, 1, 'h03, 0, 0, "sub5_2");
    run(0, 5, 2, 4, 'h00, 0, 0, "and5_2");
    run(0, 5, 2, 5, 'h07, 0, 0, "or5_2");
    run(0, 2, 5, 1, 'hFD, 0, 0, "sub2_5");
    run(0, 15, 15, 0, 'h1E, 0, 0, "add15_15");
    run(0, 15, 15, 2, 'hE1, 0, 4, "mul15_15");
    run(0, 5, 2, 3, 'h12, 0, 4, "div5_2");
    run(0, 5, 0, 3, 'hFF, 1, 0, "div5_0");
    run(0, 3, 4, 7, 'h00, 1, 0, "invalid");
    run(0, 1, 1, 0, 'h02, 0, 0, "add_clears_err");
    // start pulsed while busy must be dropped
    @(negedge clk) drive(0, 3, 3, 2, 1'b1);
    @(negedge clk) drive(0, 1, 1, 0, 1'b0);
    chk("ign busy", 32'(if4.busy), 1);
    @(negedge clk) drive(0, 1, 1, 0, 1'b1);
    @(negedge clk) drive(0, 1, 1, 0, 1'b0);
    cnt = 0;
    while (if4.res_valid !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    chk("ign res", rs(0), 9);
    @(negedge clk);
    chk("ign no_extra", 32'(if4.res_valid), 0);
    chk("ign held", rs(0), 9);
    // level-held start re-triggers every cycle for 1-cycle ops
    @(negedge clk) drive(0, 1, 2, 0, 1'b1);
    cnt = 0;
    repeat (3) begin @(negedge clk); if (if4.res_valid === 1'b1) cnt++; end
    drive(0, 1, 2, 0, 1'b0);
    chk("held add count", cnt, 3);
    chk("held add res", rs(0), 3);
    // held start on mul: re-accepted in the res_valid cycle
    @(negedge clk) drive(0, 2, 3, 2, 1'b1);
    cnt = 0;
    repeat (10) begin @(negedge clk); if (if4.res_valid === 1'b1) cnt++; end
    drive(0, 2, 3, 2, 1'b0);
    chk("held mul count", cnt, 2);
    chk("held mul res", rs(0), 6);
    repeat (2) @(negedge clk);
    // reset during mul cycle 2
    @(negedge clk) drive(0, 7, 7, 2, 1'b1);
    @(negedge clk) drive(0, 7, 7, 2, 1'b0);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("midrst busy", 32'(if4.busy), 0);
    chk("midrst valid", 32'(if4.res_valid), 0);
    chk("midrst res", rs(0), 0);
    chk("midrst err", 32'(if4.err), 0);
    @(negedge clk) rst = 1'b0;
    cnt = 0;
    repeat (8) begin @(negedge clk); if (if4.res_valid === 1'b1) cnt++; end
    chk("midrst no_valid", cnt, 0);
    run(0, 7, 7, 2, 'h31, 0, 4, "mul_after_rst");
    v8 = 0;
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      f = $urandom_range(0, 7);
      r = model(8, a, b, f, e);
      n8++;
      run(1, a, b, f, r, e, (f == 2 || (f == 3 && b != 0)) ? 8 : 0, $sformatf("rnd%0d_op%0d", i, f));
    end
    chk("w8 valid_count", v8, n8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
